// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bus bundle for mem_access_unit.
// slave  : the unit side (takes requests, drives responses and memory strobes).
// master : the pipeline/memory side (drives requests and memory read data).
// Signals:
//   request  : i_req_valid, o_req_ready, i_req_we, i_req_size, i_req_unsigned,
//              i_req_addr, i_req_wdata
//   response : o_resp_valid, o_resp_err, o_resp_rdata
//   memory   : o_memread, o_memwrite, o_address, o_write_data, i_read_data
interface mem_access_unit_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_resp_valid;
  logic        o_resp_err;
  logic [31:0] o_resp_rdata;
  logic        o_memread;
  logic        o_memwrite;
  logic [31:0] o_address;
  logic [31:0] o_write_data;
  logic [31:0] i_read_data;

  modport slave (
    input  i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr,
           i_req_wdata, i_read_data,
    output o_req_ready, o_resp_valid, o_resp_err, o_resp_rdata,
           o_memread, o_memwrite, o_address, o_write_data
  );

  modport master (
    output i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr,
           i_req_wdata, i_read_data,
    input  o_req_ready, o_resp_valid, o_resp_err, o_resp_rdata,
           o_memread, o_memwrite, o_address, o_write_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a word-addressed data memory.
// Accepts one byte/half/word load or store at a time, checks alignment and
// address range, performs sub-word stores as read-modify-write, and returns a
// one-cycle response with extended load data.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : mem_access_unit_if.slave (request, response, memory bus)
module mem_access_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter logic [31:0] LAST_ADDR = 32'h000E_FFFF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  mem_access_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state, state_nxt;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_word;

  logic        ready;
  logic        accept;
  logic        req_err;
  logic [1:0]  span;
  logic [32:0] end_addr;
  logic [31:0] aligned;
  logic [31:0] merged;
  logic [31:0] shifted;
  logic [31:0] load_val;

  assign ready  = (state == IDLE) && i_rst_n;
  assign accept = bus.i_req_valid && ready;

  // End address is computed one bit wider so a request near 2^32 cannot wrap
  // past the range check.
  always_comb begin
    span = 2'd0;
    case (bus.i_req_size)
      2'b01:   span = 2'd1;
      2'b10:   span = 2'd3;
      default: span = 2'd0;
    endcase
    end_addr = {1'b0, bus.i_req_addr} + {31'b0, span};
    req_err  = (bus.i_req_size == 2'b11) ||
               ((bus.i_req_size == 2'b01) && bus.i_req_addr[0]) ||
               ((bus.i_req_size == 2'b10) && (bus.i_req_addr[1:0] != 2'b00)) ||
               (bus.i_req_addr < BASE_ADDR) ||
               (end_addr > {1'b0, LAST_ADDR});
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_word  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        r_we    <= bus.i_req_we;
        r_size  <= bus.i_req_size;
        r_uns   <= bus.i_req_unsigned;
        r_addr  <= bus.i_req_addr;
        r_wdata <= bus.i_req_wdata;
        r_err   <= req_err;
      end
      if (state == RD) begin
        r_word <= bus.i_read_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_nxt = DONE;
          end else if (bus.i_req_we && (bus.i_req_size == 2'b10)) begin
            state_nxt = WR;
          end else begin
            state_nxt = RD;
          end
        end
      end
      RD:      state_nxt = r_we ? WR : DONE;
      WR:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Store merge and load extraction share the little-endian lane offset.
  always_comb begin
    aligned = {r_addr[31:2], 2'b00};
    merged  = r_word;
    case (r_size)
      2'b00:   merged[{r_addr[1:0], 3'b000} +: 8]  = r_wdata[7:0];
      2'b01:   merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: merged = r_wdata;
    endcase
    shifted  = r_word >> {r_addr[1:0], 3'b000};
    load_val = r_word;
    case (r_size)
      2'b00:   load_val = r_uns ? {24'b0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = r_uns ? {16'b0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = r_word;
    endcase
  end

  always_comb begin
    bus.o_req_ready  = ready;
    bus.o_memread    = 1'b0;
    bus.o_memwrite   = 1'b0;
    bus.o_address    = '0;
    bus.o_write_data = '0;
    bus.o_resp_valid = 1'b0;
    bus.o_resp_err   = 1'b0;
    bus.o_resp_rdata = '0;
    case (state)
      RD: begin
        bus.o_memread = 1'b1;
        bus.o_address = aligned;
      end
      WR: begin
        bus.o_memwrite   = 1'b1;
        bus.o_address    = aligned;
        bus.o_write_data = merged;
      end
      DONE: begin
        bus.o_resp_valid = 1'b1;
        bus.o_resp_err   = r_err;
        if (!r_err && !r_we) begin
          bus.o_resp_rdata = load_val;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, reset corner
// sequences, and randomized requests checked against a byte-level model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit #(
    .BASE_ADDR(32'h0000_3000),
    .LAST_ADDR(32'h000E_FFFF)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  // Backing memory: 1 KiB window at 0x3000; reads elsewhere return 0.
  logic [31:0] mem [0:255] = '{default: '0};
  logic        mem_hit;
  assign mem_hit = (bus.o_address[31:10] == 22'h00000C);
  assign bus.i_read_data = mem_hit ? mem[bus.o_address[9:2]] : '0;
  always @(posedge clk) begin
    if (bus.o_memwrite && mem_hit) mem[bus.o_address[9:2]] <= bus.o_write_data;
  end

  // Reference model: plain byte array over the same window.
  byte unsigned ref_b [0:1023] = '{default: 8'h00};

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_err(input logic [1:0] size, input logic [31:0] addr);
    longint unsigned last;
    last = longint'(addr) + nbytes(size) - 1;
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
           (size == 2'd2 && addr % 4 != 0) || (addr < 32'h3000) ||
           (last > 64'h000E_FFFF);
  endfunction

  function automatic logic [7:0] m_byte(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'h3000;
    if (a >= 32'h3000 && off < 1024) return ref_b[off[9:0]];
    return 8'h00;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                         input logic [31:0] addr);
    logic [31:0] v;
    int nb;
    nb = nbytes(size);
    v = '0;
    for (int i = 0; i < nb; i++) v = v | (32'(m_byte(addr + i)) << (8 * i));
    if (!uns && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  task automatic m_store(input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
    logic [31:0] off;
    for (int i = 0; i < nbytes(size); i++) begin
      off = addr + i - 32'h3000;
      if (off < 1024) ref_b[off[9:0]] = 8'((wdata >> (8 * i)) & 32'hFF);
    end
  endtask

  // One request, observed for six cycles after acceptance.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic got_err, output logic [31:0] got_rdata,
                        output int got_lat);
    logic        e;
    logic [31:0] exp_rd, exp_wd, al, wd_seen;
    int          exp_lat, rdm, wrm, exp_rdm, exp_wrm, nresp, bad;
    e  = m_err(size, addr);
    al = {addr[31:2], 2'b00};
    exp_rd = (!e && !we) ? m_load(size, uns, addr) : '0;
    if (e)                    begin exp_lat = 1; exp_rdm = 0;  exp_wrm = 0; end
    else if (!we)             begin exp_lat = 2; exp_rdm = 2;  exp_wrm = 0; end
    else if (size == 2'd2)    begin exp_lat = 2; exp_rdm = 0;  exp_wrm = 2; end
    else                      begin exp_lat = 3; exp_rdm = 2;  exp_wrm = 4; end
    if (we && !e) m_store(size, addr, wdata);
    exp_wd = m_load(2'd2, 1'b1, al);
    if (we && !e && size == 2'd2) exp_wd = wdata;

    @(negedge clk);
    chk("ready_idle", {31'b0, bus.o_req_ready}, 32'd1);
    bus.i_req_valid = 1'b1; bus.i_req_we = we; bus.i_req_size = size;
    bus.i_req_unsigned = uns; bus.i_req_addr = addr; bus.i_req_wdata = wdata;
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0; bus.i_req_we = $urandom; bus.i_req_size = 2'($urandom);
    bus.i_req_unsigned = $urandom; bus.i_req_addr = $urandom; bus.i_req_wdata = $urandom;
    rdm = 0; wrm = 0; nresp = 0; bad = 0; wd_seen = '0;
    got_lat = 0; got_err = 1'bx; got_rdata = 'x;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (bus.o_memread) rdm |= (1 << k);
      if (bus.o_memwrite) begin wrm |= (1 << k); wd_seen = bus.o_write_data; end
      if (bus.o_memread && bus.o_memwrite) bad++;
      if ((bus.o_memread || bus.o_memwrite) && bus.o_address !== al) bad++;
      if (!bus.o_memread && !bus.o_memwrite && bus.o_address !== '0) bad++;
      if (!bus.o_memwrite && bus.o_write_data !== '0) bad++;
      if (bus.o_resp_valid) begin
        if (nresp == 0) begin
          got_lat = k; got_err = bus.o_resp_err; got_rdata = bus.o_resp_rdata;
        end
        nresp++;
      end
    end
    chk("latency", got_lat, exp_lat);
    chk("resp_count", nresp, 1);
    chk("read_cycles", rdm, exp_rdm);
    chk("write_cycles", wrm, exp_wrm);
    chk("resp_err", {31'b0, got_err}, {31'b0, e});
    chk("resp_rdata", got_rdata, exp_rd);
    chk("bus_rules", bad, 0);
    if (we && !e) chk("write_data", wd_seen, exp_wd);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [20];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ge;
    logic [31:0] gr, acc;
    int          gl;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h3000,  32'hDEADBEEF, 1'b0, 32'h0,       2};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h3000,  32'h0,        1'b0, 32'hDEADBEEF, 2};
    vecs[2]  = '{1'b1, 2'd2, 1'b0, 32'h3004,  32'h11223344, 1'b0, 32'h0,       2};
    vecs[3]  = '{1'b1, 2'd0, 1'b0, 32'h3006,  32'h000000AA, 1'b0, 32'h0,       3};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h3004,  32'h0,        1'b0, 32'h11AA3344, 2};
    vecs[5]  = '{1'b1, 2'd2, 1'b0, 32'h3008,  32'h80F00000, 1'b0, 32'h0,       2};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h300A,  32'h0,        1'b0, 32'hFFFF80F0, 2};
    vecs[7]  = '{1'b0, 2'd0, 1'b1, 32'h300B,  32'h0,        1'b0, 32'h00000080, 2};
    vecs[8]  = '{1'b0, 2'd1, 1'b0, 32'h3001,  32'h0,        1'b1, 32'h0,       1};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h3002,  32'h0,        1'b1, 32'h0,       1};
    vecs[10] = '{1'b0, 2'd3, 1'b0, 32'h3000,  32'h0,        1'b1, 32'h0,       1};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h0FFC,  32'h0,        1'b1, 32'h0,       1};
    vecs[12] = '{1'b0, 2'd2, 1'b0, 32'hF0000, 32'h0,        1'b1, 32'h0,       1};
    vecs[13] = '{1'b0, 2'd2, 1'b0, 32'hEFFFC, 32'h0,        1'b0, 32'h0,       2};
    vecs[14] = '{1'b0, 2'd0, 1'b0, 32'hEFFFF, 32'h0,        1'b0, 32'h0,       2};
    vecs[15] = '{1'b1, 2'd1, 1'b0, 32'h3006,  32'h1234BEEF, 1'b0, 32'h0,       3};
    vecs[16] = '{1'b0, 2'd2, 1'b0, 32'h3004,  32'h0,        1'b0, 32'hBEEF3344, 2};
    vecs[17] = '{1'b1, 2'd2, 1'b0, 32'h2FFC,  32'h55555555, 1'b1, 32'h0,       1};
    vecs[18] = '{1'b0, 2'd0, 1'b0, 32'h3000,  32'h0,        1'b0, 32'hFFFFFFEF, 2};
    vecs[19] = '{1'b1, 2'd0, 1'b0, 32'hEFFFF, 32'h0,        1'b0, 32'h0,       3};

    // Reset held with a pending request.
    bus.i_req_valid = 1'b1; bus.i_req_we = 1'b1; bus.i_req_size = 2'd2;
    bus.i_req_unsigned = 1'b0; bus.i_req_addr = 32'h3000; bus.i_req_wdata = 32'h12345678;
    acc = '0;
    repeat (3) begin
      @(negedge clk);
      acc = acc | bus.o_resp_rdata | bus.o_address | bus.o_write_data |
            {27'b0, bus.o_resp_valid, bus.o_resp_err, bus.o_memread,
             bus.o_memwrite, bus.o_req_ready};
    end
    chk("reset_outputs", acc, 32'h0);
    bus.i_req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", {31'b0, bus.o_req_ready}, 32'd1);

    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, ge, gr, gl);
      chk($sformatf("vec%0d_err", i), {31'b0, ge}, {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d_rdata", i), gr, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_lat", i), gl, vecs[i].exp_lat);
    end

    // Reset during the RD cycle of a byte store: memory must stay intact.
    do_req(1'b1, 2'd2, 1'b0, 32'h3010, 32'hCAFEF00D, ge, gr, gl);
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_req_we = 1'b1; bus.i_req_size = 2'd0;
    bus.i_req_addr = 32'h3011; bus.i_req_wdata = 32'h55;
    @(posedge clk); #1 bus.i_req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_in_rd", {31'b0, bus.o_memread}, 32'd1);
    rst_n = 1'b0;
    acc = '0;
    repeat (2) begin
      @(negedge clk);
      acc = acc | {30'b0, bus.o_resp_valid, bus.o_memwrite};
    end
    chk("rmw_reset_quiet", acc, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rmw_reset_ready", {31'b0, bus.o_req_ready}, 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h3010, 32'h0, ge, gr, gl);
    chk("rmw_reset_mem", gr, 32'hCAFEF00D);

    // Reset coinciding with the end of WR: the write still lands.
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_req_we = 1'b1; bus.i_req_size = 2'd2;
    bus.i_req_addr = 32'h3014; bus.i_req_wdata = 32'h0BADF00D;
    @(posedge clk); #1 bus.i_req_valid = 1'b0;
    @(negedge clk);
    chk("wr_in_wr", {31'b0, bus.o_memwrite}, 32'd1);
    rst_n = 1'b0;
    acc = '0;
    repeat (2) begin
      @(negedge clk);
      acc = acc | {31'b0, bus.o_resp_valid};
    end
    chk("wr_reset_noresp", acc, 32'h0);
    rst_n = 1'b1;
    m_store(2'd2, 32'h3014, 32'h0BADF00D);
    do_req(1'b0, 2'd2, 1'b0, 32'h3014, 32'h0, ge, gr, gl);
    chk("wr_reset_mem", gr, 32'h0BADF00D);

    // Randomized traffic around the lower window edge.
    for (int n = 0; n < 300; n++) begin
      do_req(1'($urandom), 2'($urandom), 1'($urandom),
             32'h2FF8 + $urandom_range(0, 32'h110), $urandom, ge, gr, gl);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator side of the data-memory interface: sits in the MEM stage between the pipeline and the word-addressed data memory, and drives `o_memread`, `o_memwrite`, `o_address` and `o_write_data`. It accepts one load or store request at a time, in byte, halfword or word size. Sub-word stores are performed as read-modify-write, because the memory only stores whole words. The unit also applies alignment and address-range checks and returns a single-cycle response to the pipeline.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_3000: lowest legal byte address of data memory.
- `LAST_ADDR`, 32'h000E_FFFF: highest legal byte address of data memory.

Ports:
- `i_clk`, in, 1: clock; all state changes on the rising edge.
- `i_rst_n`, in, 1: reset; synchronous, active-low.
- `i_req_valid`, in, 1: request present.
- `o_req_ready`, out, 1: unit idle and able to accept a request.
- `i_req_we`, in, 1: 1 = store, 0 = load.
- `i_req_size`, in, 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `i_req_unsigned`, in, 1: loads only; zero-extend when 1, sign-extend when 0.
- `i_req_addr`, in, 32: byte address.
- `i_req_wdata`, in, 32: store data, right-aligned.
- `o_resp_valid`, out, 1: one-cycle completion pulse.
- `o_resp_err`, out, 1: request rejected; qualified by `o_resp_valid`.
- `o_resp_rdata`, out, 32: extended load data; 0 for stores and errors.
- `o_memread`, out, 1: memory read strobe.
- `o_memwrite`, out, 1: memory write strobe.
- `o_address`, out, 32: byte address to memory; bits [1:0] are always 0.
- `o_write_data`, out, 32: full word to write.
- `i_read_data`, in, 32: memory read data; combinational from `o_address` within the same cycle.

## Operation
- **FSM states:** IDLE, RD, WR, DONE.
- **Handshake:** `o_req_ready` = (state == IDLE) && `i_rst_n`. A request is accepted on a rising edge where `i_req_valid` && `o_req_ready`. All request fields are latched at that edge. Inputs are ignored outside IDLE.
- **Error check at acceptance.** The request is an error if any of the following holds:
  - size = 11;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr < `BASE_ADDR`;
  - addr + bytes − 1 > `LAST_ADDR`.

  An error request goes IDLE → DONE with `o_resp_err` = 1. No memory strobe is issued.
- **State transitions:**
  - Load: IDLE → RD → DONE.
  - Word store: IDLE → WR → DONE.
  - Byte or half store: IDLE → RD → WR → DONE.
  - DONE → IDLE unconditionally.
- **RD state:** `o_memread` = 1 and `o_address` = {addr[31:2], 2'b00}. `i_read_data` is captured into an internal word register at the end of the cycle.
- **WR state:** `o_memwrite` = 1 and `o_address` = the aligned address. `o_write_data` is:
  - word: `i_req_wdata`;
  - byte: captured word with lane addr[1:0] (bits [8k+7:8k]) replaced by wdata[7:0];
  - half: captured word with lane addr[1] (bits [16k+15:16k]) replaced by wdata[15:0].

  The memory commits the write at the rising edge that ends the WR cycle.
- **Load extraction (little-endian):**
  - byte: lane addr[1:0];
  - half: lane addr[1];
  - word: the whole word.

  The extracted value is sign- or zero-extended to 32 bits per `i_req_unsigned`. It is driven on `o_resp_rdata` in DONE.
- **Outside their state**, `o_memread` and `o_memwrite` are 0, and `o_address` and `o_write_data` are 0. `o_memread` and `o_memwrite` are never asserted together.
- **Reset values:** state IDLE. `o_resp_valid`, `o_resp_err`, `o_resp_rdata`, `o_memread`, `o_memwrite`, `o_address` and `o_write_data` are all 0. `o_req_ready` is 0 while `i_rst_n` = 0 and 1 in the first cycle after release.
- **Reset mid-operation:** the pending request is dropped and no response is produced. If the reset edge coincides with the end of a WR cycle, the memory still commits that write. A read-modify-write interrupted in RD leaves memory unchanged.

## Timing
- All outputs except `o_req_ready` are registered, i.e. decoded from the state register and latched request fields.
- Latency is counted from the acceptance edge (edge 0):
  - load: `o_memread` during cycle 1, `o_resp_valid` during cycle 2;
  - word store: `o_memwrite` during cycle 1, response in cycle 2;
  - sub-word store: read in cycle 1, write in cycle 2, response in cycle 3;
  - error: response in cycle 1.
- The next request can be accepted at the edge that ends DONE. Throughput is therefore one request per 2, 3 or 4 cycles, depending on the request type.
- `o_resp_valid` is high for exactly one cycle per accepted request.

## Test plan
- **Reset:** hold `i_rst_n` = 0 for 3 cycles with `i_req_valid` = 1 → all outputs 0, no strobes. After release, `o_req_ready` = 1.
- **Word store then load:**
  - Word store of 32'hDEADBEEF to 32'h3000 → `o_memwrite` for 1 cycle with `o_address` = 32'h3000, response in cycle 2.
  - Word load from 32'h3000 → `o_resp_rdata` = 32'hDEADBEEF in cycle 2.
- **Byte store RMW:** memory at 32'h3004 holds 32'h11223344. Byte store of 8'hAA to 32'h3006 → RD then WR with `o_write_data` = 32'h11AA3344, response in cycle 3.
- **Sub-word load extension:** memory at 32'h3008 holds 32'h80F0_0000.
  - Signed half load from 32'h300A → 32'hFFFF80F0.
  - Unsigned byte load from 32'h300B → 32'h00000080.
- **Errors:** each of the following gives a response in cycle 1 with `o_resp_err` = 1, `o_resp_rdata` = 0, and no `o_memread`/`o_memwrite` pulse:
  - half at 32'h3001;
  - word at 32'h3002;
  - size 11;
  - word at 32'h0FFC;
  - word at 32'hF0000.
- **Reset during RMW:** assert reset during the RD cycle of a byte store → memory unchanged, no `o_resp_valid`, unit idle after release.
